aim_matcher: RTL and testbench

- Associative index matcher for the object-tracking datapath.
- Holds 32 query words and scans one 32-entry window of a 256-entry index array (IA), selected by iteration number i_ite.
- For each word, reports whether its key appears in the window and the absolute IA position of the first match.
- Sits between the feature/word generator and the tracking update logic. The downstream logic iterates i_ite 0..7 to cover all of IA.

---
 rtl/aim_pkg.sv | 26 ++
 rtl/aim_lane.sv | 43 ++++
 rtl/aim_matcher.sv | 99 +++++++++
 tb/tb_aim_matcher.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/aim_pkg.sv
// Shared constants, types and helpers for the associative index matcher.
package aim_pkg;

    localparam int N_WORD = 32;
    localparam int N_IA   = 256;
    localparam int WORD_W = 16;
    localparam int KEY_W  = 6;
    localparam int POS_W  = 9;
    localparam int ITE_W  = 3;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [POS_W-1:0] pos_t;

    // Absolute IA index of window entry j in iteration ite; MSB is always zero.
    function automatic pos_t make_pos(input logic [ITE_W-1:0] ite, input logic [CNT_W-1:0] j);
        return {1'b0, ite, j};
    endfunction

endpackage

// File: rtl/aim_lane.sv
// One query lane: compares its key against the streamed window entry and
// keeps the first matching position.
module aim_lane
    import aim_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] entry,
    input  logic [POS_W-1:0] idx,
    output logic             valid,
    output logic [POS_W-1:0] pos
);

    logic hit_s;

    // A lane only captures while unmatched, so the earliest match is kept.
    always_comb begin
        hit_s = 1'b0;
        if (enable && !valid && (key == entry)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Result registers with clear on accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pos   <= {POS_W{1'b0}};
        end else if (clear) begin
            valid <= 1'b0;
            pos   <= {POS_W{1'b0}};
        end else if (hit_s) begin
            valid <= 1'b1;
            pos   <= idx;
        end
    end

endmodule

// File: rtl/aim_matcher.sv
// Associative index matcher: scans one 32-entry IA window per run and reports
// per-word first-match positions.
module aim_matcher
    import aim_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ITE_W-1:0]  i_ite,
    input  logic [WORD_W-1:0] i_word [0:N_WORD-1],
    input  logic [KEY_W-1:0]  i_IA   [0:N_IA-1],
    output logic              o_finish,
    output logic              o_valid [0:N_WORD-1],
    output logic [POS_W-1:0]  o_pos   [0:N_WORD-1]
);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [ITE_W-1:0] ite_r;
    key_t             key_r [0:N_WORD-1];
    key_t             entry_s;
    pos_t             idx_s;
    logic             clear_s;
    logic             scan_s;
    logic             unused_word_s;

    // Window mux: the IA is read live at the latched iteration and counter.
    always_comb begin
        entry_s = i_IA[{ite_r, cnt_r}];
        idx_s   = make_pos(ite_r, cnt_r);
        clear_s = (state_r == IDLE) && i_start;
        scan_s  = (state_r == SCAN);
    end

    // Upper word bits carry no key information.
    always_comb begin
        unused_word_s = 1'b0;
        for (int i = 0; i < N_WORD; i++) begin
            unused_word_s = unused_word_s ^ (^i_word[i][WORD_W-1:KEY_W]);
        end
    end

    // Control FSM: latch on start, 32 scan cycles, one done cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            ite_r    <= {ITE_W{1'b0}};
            o_finish <= 1'b0;
            for (int i = 0; i < N_WORD; i++) begin
                key_r[i] <= {KEY_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    o_finish <= 1'b0;
                    if (i_start) begin
                        ite_r   <= i_ite;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= SCAN;
                        for (int i = 0; i < N_WORD; i++) begin
                            key_r[i] <= i_word[i][KEY_W-1:0];
                        end
                    end
                end
                SCAN: begin
                    o_finish <= 1'b0;
                    cnt_r    <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    o_finish <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    o_finish <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_WORD; g++) begin : g_lane
        aim_lane u_lane (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .clear  (clear_s),
            .enable (scan_s),
            .key    (key_r[g]),
            .entry  (entry_s),
            .idx    (idx_s),
            .valid  (o_valid[g]),
            .pos    (o_pos[g])
        );
    end

endmodule

// File: tb/tb_aim_matcher.sv
// Directed self-checking bench for aim_matcher.
module tb_aim_matcher;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [2:0]  i_ite;
    logic [15:0] word [0:31];
    logic [5:0]  ia   [0:255];
    logic        o_finish;
    logic        valid [0:31];
    logic [8:0]  pos   [0:31];

    int          n_total = 0;
    int          n_bad   = 0;
    int          ev [0:31];
    int          ep [0:31];
    int          cyc;
    int          fin_cnt;

    aim_matcher dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_ite    (i_ite),
        .i_word   (word),
        .i_IA     (ia),
        .o_finish (o_finish),
        .o_valid  (valid),
        .o_pos    (pos)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: first window entry equal to each word's low 6 bits.
    task automatic model(input int ite);
        for (int i = 0; i < 32; i++) begin
            ev[i] = 0;
            ep[i] = 0;
            for (int j = 0; j < 32; j++) begin
                if (ev[i] == 0 && ia[ite*32 + j] == word[i][5:0]) begin
                    ev[i] = 1;
                    ep[i] = ite*32 + j;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("%s_valid%0d", tag, i), int'(valid[i]), ev[i]);
            check_eq($sformatf("%s_pos%0d", tag, i), int'(pos[i]), ep[i]);
        end
    endtask

    // Pulse start, optionally re-pulse at cycle restart_at, count cycles to o_finish.
    task automatic run(input int ite, input int restart_at, output int cycles);
        @(negedge i_clk);
        i_ite   = ite[2:0];
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        cycles  = 0;
        fin_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge i_clk);
            #1;
            cycles++;
            i_start = (cycles == restart_at) ? 1'b1 : 1'b0;
            if (o_finish) begin
                fin_cnt++;
                break;
            end
        end
        i_start = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 32; i++) word[i] = 16'(2*i);
        for (int j = 0; j < 256; j++) ia[j] = (j < 32) ? 6'(3*j) : 6'(j ^ 8'h2A);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_ite   = 3'd0;
        for (int i = 0; i < 32; i++) word[i] = 16'd0;
        for (int j = 0; j < 256; j++) ia[j] = 6'd0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("rst_finish", int'(o_finish), 0);
        check_eq("rst_valid0", int'(valid[0]), 0);
        check_eq("rst_pos31", int'(pos[31]), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Basic match, ite 0
        load_basic();
        run(0, -1, cyc);
        check_eq("basic_latency", cyc, 33);
        check_eq("basic_v0", int'(valid[0]), 1);
        check_eq("basic_p0", int'(pos[0]), 0);
        check_eq("basic_v1", int'(valid[1]), 1);
        check_eq("basic_p1", int'(pos[1]), 22);
        check_eq("basic_v2", int'(valid[2]), 0);
        check_eq("basic_v3", int'(valid[3]), 1);
        check_eq("basic_p3", int'(pos[3]), 2);
        model(0);
        check_all("basic");
        @(posedge i_clk);
        #1;
        check_eq("basic_finish_pulse", int'(o_finish), 0);
        repeat (5) @(posedge i_clk);
        #1;
        check_eq("basic_hold_p1", int'(pos[1]), 22);

        // Ignored restart six cycles in
        run(0, 6, cyc);
        check_eq("restart_latency", cyc, 33);
        check_all("restart");
        fin_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_finish) fin_cnt++;
        end
        check_eq("restart_no_second_finish", fin_cnt, 0);

        // Window select, ite 5
        for (int i = 0; i < 32; i++) word[i] = 16'hFC00 | 16'(i);
        for (int j = 0; j < 256; j++) ia[j] = (j >= 160 && j < 192) ? 6'h3F : 6'(j % 32);
        ia[167] = 6'd4;
        run(5, -1, cyc);
        check_eq("win_latency", cyc, 33);
        check_eq("win_v4", int'(valid[4]), 1);
        check_eq("win_p4", int'(pos[4]), 167);
        check_eq("win_v5", int'(valid[5]), 0);
        model(5);
        check_all("win");

        // First-match priority, ite 2
        for (int j = 64; j < 96; j++) ia[j] = 6'h3F;
        ia[67] = 6'd0;
        ia[74] = 6'd0;
        run(2, -1, cyc);
        check_eq("prio_p0", int'(pos[0]), 67);
        check_eq("prio_v0", int'(valid[0]), 1);
        model(2);
        check_all("prio");

        // Reset mid-scan
        load_basic();
        @(negedge i_clk);
        i_ite   = 3'd0;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        check_eq("midrst_pre_v0", int'(valid[0]), 1);
        i_rst_n = 1'b0;
        #1;
        check_eq("midrst_v0", int'(valid[0]), 0);
        check_eq("midrst_p3", int'(pos[3]), 0);
        check_eq("midrst_finish", int'(o_finish), 0);
        fin_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_finish) fin_cnt++;
            if (k == 3) i_rst_n = 1'b1;
        end
        check_eq("midrst_no_finish", fin_cnt, 0);
        run(0, -1, cyc);
        check_eq("post_rst_latency", cyc, 33);
        model(0);
        check_all("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
